// File: rtl/seg_pkg.sv
// Shared display constants for the seven-segment display blocks.
package seg_pkg;

  localparam int unsigned DIGITS_DEFAULT = 8;

  // Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low polarities for the digit enables and the decimal point
  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Hex glyphs 0..F, active-low {g..a}
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    seg = hex_glyph(nibble);
  end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed seven-segment scanner: advances one digit per rising edge
// of the (asynchronous) scan_clk input and latches a new value per frame.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS           = DIGITS_DEFAULT,
  parameter int          BLANK_LZ_DEFAULT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // BLANK_LZ_DEFAULT is the value integrators tie blank_en to; only 0/1 are meaningful
  if (BLANK_LZ_DEFAULT != 0 && BLANK_LZ_DEFAULT != 1) begin : g_bad_blank_default
    $error("seg_scanner: BLANK_LZ_DEFAULT must be 0 or 1");
  end

  logic                  s1, s2, s3;
  logic                  scan_tick;
  logic                  wrap;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   data_lat;
  logic [DIGITS-1:0]     dp_lat;

  logic [DIGITS-1:0]     lz;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  blank_sel;
  logic [DIGITS-1:0]     an_nxt;
  logic [6:0]            seg_dec;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // Two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign scan_tick = s2 & ~s3;
  assign wrap      = scan_tick && (idx == IDX_LAST);

  // Digit index advance and whole-frame latch on the wrap to digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= IDX_LAST;
      data_lat   <= '0;
      dp_lat     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (scan_tick) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      if (wrap) begin
        data_lat <= data;
        dp_lat   <= dp_mask;
      end
    end
  end

  // Leading-zero map: lz[i] set when latched nibbles i..DIGITS-1 are all zero
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      run = run & (data_lat[4*(DIGITS-1-k) +: 4] == 4'h0);
      lz[DIGITS-1-k] = run;
    end
    lz[0] = 1'b0;
  end

  // Select the current digit's nibble, dp request and blanking; build the enable
  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_nxt    = {DIGITS{AN_OFF}};
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_sel   = data_lat[4*i +: 4];
        dp_sel    = dp_lat[i];
        blank_sel = blank_en & lz[i];
        an_nxt[i] = AN_ON;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  // Blanking overrides segments only; the decimal point is independent
  always_comb begin
    seg_nxt = blank_sel ? SEG_BLANK : seg_dec;
    dp_nxt  = dp_sel ? DP_ON : DP_OFF;
  end

  // Registered display outputs, one clk behind the index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= {DIGITS{AN_OFF}};
      seg <= SEG_BLANK;
      dp  <= DP_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scanner.sv
// Directed self-checking bench for seg_scanner.
module tb_seg_scanner;

  logic        clk;
  logic        rst_n;
  logic        scan_clk;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        blank_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         GA = 7'b0001000, GC = 7'b1000110, GD = 7'b0100001,
                         GF = 7'b0001110, GBL = 7'h7F;

  seg_scanner #(.DIGITS(8), .BLANK_LZ_DEFAULT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_en   (blank_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full scan_clk period (high 4 clk, low 3 clk); counts frame_done pulses
  task automatic scan_step(output int fd_cnt);
    fd_cnt = 0;
    scan_clk = 1'b1;
    repeat (4) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    scan_clk = 1'b0;
    repeat (3) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
  endtask

  initial begin
    int fd;
    logic       stable;
    logic [15:0] snap;

    rst_n = 1'b0; scan_clk = 1'b0; data = '0; dp_mask = '0; blank_en = 1'b0;

    // Reset held while scan_clk toggles
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      scan_clk = ~scan_clk;
      repeat (2) @(negedge clk);
      check("reset_state", {an, seg, dp, frame_done}, {8'hFF, GBL, 1'b1, 1'b0});
    end
    scan_clk = 1'b0;
    repeat (3) @(negedge clk);

    // First frame
    rst_n = 1'b1; data = 32'h1234ABCD; dp_mask = 8'h00;
    repeat (2) @(negedge clk);
    check("post_rst_d7", {an, seg, dp}, {8'h7F, G0, 1'b1});
    scan_clk = 1'b1;
    repeat (3) @(negedge clk);
    check("fd_pulse", {31'd0, frame_done}, 32'd1);
    check("out_lag", {an, seg}, {8'h7F, G0});
    @(negedge clk);
    check("fd_clear", {31'd0, frame_done}, 32'd0);
    check("first_d0", {an, seg}, {8'hFE, GD});
    scan_clk = 1'b0;
    repeat (3) @(negedge clk);
    scan_step(fd);
    check("first_d1", {an, seg}, {8'hFD, GC});
    check("no_fd_d1", fd, 0);

    // Frame integrity: new data mid-frame is invisible until the wrap
    scan_step(fd);
    scan_step(fd);
    check("d3_A", {an, seg}, {8'hF7, GA});
    data = 32'hFFFFFFFF;
    scan_step(fd); check("hold_d4", {an, seg, 8'(fd)}, {8'hEF, G4, 8'd0});
    scan_step(fd); check("hold_d5", {an, seg, 8'(fd)}, {8'hDF, G3, 8'd0});
    scan_step(fd); check("hold_d6", {an, seg, 8'(fd)}, {8'hBF, G2, 8'd0});
    scan_step(fd); check("hold_d7", {an, seg, 8'(fd)}, {8'h7F, G1, 8'd0});
    scan_step(fd); check("wrap_F_d0", {an, seg, 8'(fd)}, {8'hFE, GF, 8'd1});
    scan_step(fd); check("F_d1", {an, seg}, {8'hFD, GF});

    // Blanking of leading zeros
    blank_en = 1'b1; data = 32'h00000A05; dp_mask = 8'h80;
    for (int i = 0; i < 6; i++) scan_step(fd);
    check("pre_wrap_d7", an, 8'h7F);
    scan_step(fd); check("blk_d0", {an, seg, dp, 8'(fd)}, {8'hFE, G5, 1'b1, 8'd1});
    scan_step(fd); check("blk_d1_zero", {an, seg}, {8'hFD, G0});
    scan_step(fd); check("blk_d2_A", {an, seg}, {8'hFB, GA});
    for (int i = 3; i < 7; i++) begin
      scan_step(fd);
      check("blk_upper", {an, seg, dp}, {~(8'd1 << i), GBL, 1'b1});
    end
    scan_step(fd); check("blk_d7_dp", {an, seg, dp}, {8'h7F, GBL, 1'b0});
    data = 32'h0;
    scan_step(fd); check("zero_d0", {an, seg, dp, 8'(fd)}, {8'hFE, G0, 1'b1, 8'd1});
    for (int i = 1; i < 7; i++) begin
      scan_step(fd);
      check("zero_blank", {an, seg}, {~(8'd1 << i), GBL});
    end
    scan_step(fd); check("zero_d7_dp", {an, seg, dp}, {8'h7F, GBL, 1'b0});
    blank_en = 1'b0;
    repeat (2) @(negedge clk);
    check("blank_live", {an, seg, dp}, {8'h7F, G0, 1'b0});

    // One-clk glitch, then a long stall: outputs must hold
    scan_clk = 1'b1;
    @(negedge clk);
    scan_clk = 1'b0;
    repeat (6) @(negedge clk);
    snap = {an, seg, dp};
    stable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({an, seg, dp} !== snap[15:0] || frame_done !== 1'b0) stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 32'd1);
    check("stall_end", {an, seg, dp}, snap);

    // Async reset in the middle of a frame
    data = 32'h87654321;
    for (int s = 0; s < 10 && an !== 8'hDF; s++) scan_step(fd);
    check("reach_d5", an, 8'hDF);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {an, seg, dp, frame_done}, {8'hFF, GBL, 1'b1, 1'b0});
    @(negedge clk);
    check("rst_hold", {an, seg, dp, frame_done}, {8'hFF, GBL, 1'b1, 1'b0});
    data = 32'hCAFE0123; dp_mask = 8'h01;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_d7", {an, seg, dp}, {8'h7F, G0, 1'b1});
    scan_step(fd); check("rst2_d0", {an, seg, dp, 8'(fd)}, {8'hFE, G3, 1'b0, 8'd1});
    scan_step(fd); check("rst2_d1", {an, seg, dp}, {8'hFD, G2, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
